alu_share_arbiter: RTL

//   Shares the single 16-bit ALU between two requesters (req0, req1) with a valid/ready handshake.
//   - Arbitrates between the two requesters and registers the granted operands.
//   - Sequences one ALU evaluation, then returns result and zero/negative flags to the owner.

---
 rtl/alu_share_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Two-client valid/ready arbiter that sequences one shared ALU op.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W = 16,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [2:0]        req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_neg,
    output logic              rsp_err,
    output logic              busy,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [2:0]        alu_op_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_neg
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [2:0] c_OP_ADD    = 3'b000;
    localparam logic [2:0] c_OP_XOR    = 3'b001;
    localparam logic [2:0] c_OP_SUB    = 3'b010;
    localparam logic [2:0] c_OP_PASS_B = 3'b111;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_neg;
    logic              r_err;

    logic              w_any_req;
    logic              w_grant_sel;
    logic              w_op_ok;
    logic              w_rsp_fire;
    logic              w_in_idle;
    logic              w_in_exec;
    logic              w_in_resp;

    assign w_in_idle = (r_state == c_IDLE);
    assign w_in_exec = (r_state == c_EXEC);
    assign w_in_resp = (r_state == c_RESP);
    assign w_any_req = req0_valid | req1_valid;

    // On contention the round-robin pick is whichever client did not win last.
    always_comb begin
        w_grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_sel = RR_EN ? ~r_last_grant : 1'b0;
        end else begin
            w_grant_sel = req1_valid;
        end
    end

    assign req0_ready = w_in_idle & w_any_req & ~w_grant_sel;
    assign req1_ready = w_in_idle & w_any_req &  w_grant_sel;

    assign w_op_ok = (r_op == c_OP_ADD) || (r_op == c_OP_XOR) ||
                     (r_op == c_OP_SUB) || (r_op == c_OP_PASS_B);

    // The ALU only ever sees registered operands during EXEC; otherwise a safe PASS_B of zero.
    assign alu_in_a   = w_in_exec ? r_a : '0;
    assign alu_in_b   = w_in_exec ? r_b : '0;
    assign alu_op_sel = (w_in_exec && w_op_ok) ? r_op : c_OP_PASS_B;

    assign rsp0_valid = w_in_resp & ~r_owner;
    assign rsp1_valid = w_in_resp &  r_owner;
    assign w_rsp_fire = w_in_resp & (r_owner ? rsp1_ready : rsp0_ready);

    assign rsp_result = r_result;
    assign rsp_zero   = r_zero;
    assign rsp_neg    = r_neg;
    assign rsp_err    = r_err;
    assign busy       = ~w_in_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= 3'b000;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_neg        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant_sel;
                        r_a     <= w_grant_sel ? req1_a  : req0_a;
                        r_b     <= w_grant_sel ? req1_b  : req0_b;
                        r_op    <= w_grant_sel ? req1_op : req0_op;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (w_op_ok) begin
                        r_result <= alu_result;
                        r_zero   <= alu_zero;
                        r_neg    <= alu_neg;
                        r_err    <= 1'b0;
                    end else begin
                        r_result <= '0;
                        r_zero   <= 1'b0;
                        r_neg    <= 1'b0;
                        r_err    <= 1'b1;
                    end
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    if (w_rsp_fire) begin
                        r_last_grant <= r_owner;
                        r_state      <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
